// File: rtl/barker_pkg.sv
// rtl/barker_pkg.sv - shared types, LFSR taps and symbol mapping for the Barker burst generator
package barker_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_GAP  = 2'd2
    } gen_state_t;

    // Galois right-shift feedback mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Raw bit when data_w==1, otherwise two's-complement +ampl / -ampl
    function automatic logic [31:0] chip_to_symbol(input logic chip, input int data_w, input int ampl);
        if (data_w == 1) begin
            return {31'b0, chip};
        end
        return chip ? 32'(ampl) : 32'(-ampl);
    endfunction

endpackage

// File: rtl/barker_burst_gen_if.sv
// rtl/barker_burst_gen_if.sv - stream bundle carrying chips/symbols out of the generator
interface barker_burst_gen_if #(
    parameter int DATA_W = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/barker_lfsr16.sv
// rtl/barker_lfsr16.sv - 16-bit Galois LFSR with step enable, also used by the correlator noise source
module barker_lfsr16
    import barker_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next state: shift right, fold the feedback mask in when the outgoing bit is 1
    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
        end
    end

    // State register, reloads the seed on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/barker_burst_gen.sv
// rtl/barker_burst_gen.sv - framed Barker code stream source with gaps, frame count and error injection
module barker_burst_gen
    import barker_pkg::*;
#(
    parameter int          SEQ_LEN   = 11,
    parameter logic [31:0] SEQ       = 32'h0000_0712,
    parameter int          DATA_W    = 1,
    parameter int          AMPL      = 1,
    parameter int          PAUSE_W   = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [15:0]        i_n_frames,
    input  logic               i_rand_gap,
    input  logic [PAUSE_W-1:0] i_gap_len,
    input  logic               i_flip_en,
    input  logic [4:0]         i_flip_idx,
    barker_burst_gen_if.master m_axis,
    output logic               o_busy,
    output logic [15:0]        o_frame_cnt
);

    localparam logic [4:0]         LAST_IDX = 5'(SEQ_LEN - 1);
    localparam logic [31:0]        SEQ_V    = SEQ;
    localparam logic [PAUSE_W-1:0] GAP_ONE  = PAUSE_W'(1);

    gen_state_t         state_q, state_d;
    logic [4:0]         chip_idx_q, chip_idx_d;
    logic               flip_en_q, flip_en_d;
    logic [4:0]         flip_idx_q, flip_idx_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               stop_pending_q, stop_pending_d;
    logic [PAUSE_W-1:0] gap_cnt_q, gap_cnt_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               tuser_q, tuser_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic               busy_q, busy_d;

    logic               lfsr_step;
    logic [15:0]        lfsr_state;
    logic               stop_req;
    logic               hs;
    logic [PAUSE_W-1:0] gap_sel;
    logic [4:0]         bit_sel;
    logic               chip_bit;

    barker_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Next-state logic; outputs are derived from the next chip index so they can be registered
    always_comb begin
        state_d        = state_q;
        chip_idx_d     = chip_idx_q;
        flip_en_d      = flip_en_q;
        flip_idx_d     = flip_idx_q;
        frame_cnt_d    = frame_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        lfsr_step      = 1'b0;
        stop_req       = stop_pending_q | i_stop;
        stop_pending_d = stop_req;
        hs             = tvalid_q & m_axis.tready;
        gap_sel        = i_rand_gap ? (PAUSE_W'(lfsr_state) & i_gap_len) : i_gap_len;

        case (state_q)
            S_IDLE: begin
                stop_pending_d = 1'b0;
                if (i_start) begin
                    state_d     = S_GEN;
                    chip_idx_d  = 5'd0;
                    frame_cnt_d = 16'd0;
                    flip_en_d   = i_flip_en;
                    flip_idx_d  = i_flip_idx;
                end
            end
            S_GEN: begin
                if (hs) begin
                    if (chip_idx_q == LAST_IDX) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        lfsr_step   = 1'b1;
                        if (((i_n_frames != 16'd0) && (frame_cnt_q + 16'd1 == i_n_frames)) || stop_req) begin
                            state_d = S_IDLE;
                        end else if (gap_sel == '0) begin
                            chip_idx_d = 5'd0;
                            flip_en_d  = i_flip_en;
                            flip_idx_d = i_flip_idx;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_sel - GAP_ONE;
                        end
                    end else begin
                        chip_idx_d = chip_idx_q + 5'd1;
                    end
                end
            end
            S_GAP: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d    = S_GEN;
                    chip_idx_d = 5'd0;
                    flip_en_d  = i_flip_en;
                    flip_idx_d = i_flip_idx;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An out-of-range flip index simply never matches a chip position
        bit_sel  = LAST_IDX - chip_idx_d;
        chip_bit = SEQ_V[bit_sel] ^ (flip_en_d && (chip_idx_d == flip_idx_d));
        tvalid_d = (state_d == S_GEN);
        tlast_d  = tvalid_d && (chip_idx_d == LAST_IDX);
        tuser_d  = tvalid_d && flip_en_d;
        tdata_d  = '0;
        if (tvalid_d) begin
            tdata_d = DATA_W'(chip_to_symbol(chip_bit, DATA_W, AMPL));
        end
        busy_d = (state_d != S_IDLE);
    end

    // FSM and registered stream outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            chip_idx_q     <= 5'd0;
            flip_en_q      <= 1'b0;
            flip_idx_q     <= 5'd0;
            frame_cnt_q    <= 16'd0;
            stop_pending_q <= 1'b0;
            gap_cnt_q      <= '0;
            tvalid_q       <= 1'b0;
            tlast_q        <= 1'b0;
            tuser_q        <= 1'b0;
            tdata_q        <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            chip_idx_q     <= chip_idx_d;
            flip_en_q      <= flip_en_d;
            flip_idx_q     <= flip_idx_d;
            frame_cnt_q    <= frame_cnt_d;
            stop_pending_q <= stop_pending_d;
            gap_cnt_q      <= gap_cnt_d;
            tvalid_q       <= tvalid_d;
            tlast_q        <= tlast_d;
            tuser_q        <= tuser_d;
            tdata_q        <= tdata_d;
            busy_q         <= busy_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign o_busy        = busy_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_barker_burst_gen.sv
// tb/tb_barker_burst_gen.sv - directed self-checking bench for barker_burst_gen
module tb_barker_burst_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, rand_gap, flip_en, tready;
    logic [15:0] n_frames;
    logic [5:0]  gap_len;
    logic [4:0]  flip_idx;
    logic        busy1, busy8;
    logic [15:0] fc1, fc8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    barker_burst_gen_if #(.DATA_W(1)) ax1 ();
    barker_burst_gen_if #(.DATA_W(8)) ax8 ();
    assign ax1.tready = tready;
    assign ax8.tready = tready;

    barker_burst_gen #(.DATA_W(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_n_frames(n_frames), .i_rand_gap(rand_gap), .i_gap_len(gap_len),
        .i_flip_en(flip_en), .i_flip_idx(flip_idx), .m_axis(ax1),
        .o_busy(busy1), .o_frame_cnt(fc1)
    );

    barker_burst_gen #(.DATA_W(8), .AMPL(1)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_n_frames(n_frames), .i_rand_gap(rand_gap), .i_gap_len(gap_len),
        .i_flip_en(flip_en), .i_flip_idx(flip_idx), .m_axis(ax8),
        .o_busy(busy8), .o_frame_cnt(fc8)
    );

    typedef struct {
        logic        fe;
        logic [4:0]  fi;
        logic [10:0] exp_bits;
        logic        exp_user;
    } vec_t;

    vec_t vecs[5];
    logic [10:0] pat;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int pbit(input logic [10:0] p, input int b);
        return int'(p >> (10 - b)) & 1;
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic start_run();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int beat, frames, idle, beats, lastflag;
        logic in_gap, prev_stall, prev_data, prev_last;
        logic [15:0] lm;
        int exp_gap;

        pat = 11'b11100010010;
        vecs[0] = '{1'b0, 5'd0,  11'b11100010010, 1'b0};
        vecs[1] = '{1'b1, 5'd3,  11'b11110010010, 1'b1};
        vecs[2] = '{1'b1, 5'd15, 11'b11100010010, 1'b1};
        vecs[3] = '{1'b1, 5'd0,  11'b01100010010, 1'b1};
        vecs[4] = '{1'b1, 5'd10, 11'b11100010011, 1'b1};

        start = 0; stop = 0; rand_gap = 0; flip_en = 0; tready = 1;
        n_frames = 16'd1; gap_len = 6'd0; flip_idx = 5'd0;

        // reset values
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_tvalid", int'(ax1.tvalid), 0);
        chk("rst_tlast", int'(ax1.tlast), 0);
        chk("rst_tuser", int'(ax1.tuser), 0);
        chk("rst_tdata8", int'(ax8.tdata), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_fcnt", int'(fc1), 0);
        rst_n = 1'b1;
        cyc();

        // single frames from the vector table
        for (int v = 0; v < 5; v++) begin
            flip_en  = vecs[v].fe;
            flip_idx = vecs[v].fi;
            n_frames = 16'd1;
            start_run();
            for (int b = 0; b < 11; b++) begin
                chk("tvalid", int'(ax1.tvalid), 1);
                chk("tdata", int'(ax1.tdata), pbit(vecs[v].exp_bits, b));
                chk("tlast", int'(ax1.tlast), (b == 10) ? 1 : 0);
                chk("tuser", int'(ax1.tuser), int'(vecs[v].exp_user));
                chk("tdata8", int'(ax8.tdata), pbit(vecs[v].exp_bits, b) ? 1 : 255);
                cyc();
            end
            chk("end_tvalid", int'(ax1.tvalid), 0);
            chk("end_busy", int'(busy1), 0);
            chk("end_fcnt", int'(fc1), 1);
        end
        flip_en = 1'b0;

        // two back-to-back frames of signed symbols
        n_frames = 16'd2;
        start_run();
        for (int b = 0; b < 22; b++) begin
            chk("b2b_tvalid", int'(ax8.tvalid), 1);
            chk("b2b_tdata8", int'(ax8.tdata), pbit(pat, b % 11) ? 1 : 255);
            chk("b2b_tlast", int'(ax8.tlast), ((b % 11) == 10) ? 1 : 0);
            cyc();
        end
        chk("b2b_tvalid_end", int'(ax8.tvalid), 0);
        chk("b2b_fcnt", int'(fc8), 2);
        chk("b2b_busy", int'(busy8), 0);

        // 100 frames, random backpressure, fixed gap of 5
        n_frames = 16'd100;
        gap_len  = 6'd5;
        start_run();
        beat = 0; frames = 0; idle = 0;
        in_gap = 0; prev_stall = 0; prev_data = 0; prev_last = 0;
        for (int c = 0; c < 20000; c++) begin
            tready = 1'($urandom_range(0, 1));
            if (ax1.tvalid) begin
                if (in_gap) begin
                    chk("gap_len", idle, 5);
                    in_gap = 0;
                end
                if (prev_stall) begin
                    chk("stall_data", int'(ax1.tdata), int'(prev_data));
                    chk("stall_last", int'(ax1.tlast), int'(prev_last));
                end
                if (tready) begin
                    chk("stream_data", int'(ax1.tdata), pbit(pat, beat));
                    chk("stream_last", int'(ax1.tlast), (beat == 10) ? 1 : 0);
                    prev_stall = 0;
                    if (beat == 10) begin
                        beat = 0;
                        frames++;
                        if (frames < 100) begin
                            in_gap = 1;
                            idle = 0;
                        end
                    end else begin
                        beat++;
                    end
                end else begin
                    prev_stall = 1;
                    prev_data  = ax1.tdata[0];
                    prev_last  = ax1.tlast;
                end
            end else if (in_gap) begin
                idle++;
            end
            cyc();
            if (frames == 100) break;
        end
        tready = 1'b1;
        chk("stream_frames", frames, 100);
        chk("stream_tvalid_end", int'(ax1.tvalid), 0);
        chk("stream_fcnt", int'(fc1), 100);
        chk("stream_busy", int'(busy1), 0);

        // LFSR-derived gaps from a fresh seed
        do_reset();
        rand_gap = 1'b1;
        gap_len  = 6'h3F;
        n_frames = 16'd8;
        lm = 16'hACE1;
        start_run();
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 11; b++) begin
                chk("rg_tvalid", int'(ax1.tvalid), 1);
                chk("rg_tlast", int'(ax1.tlast), (b == 10) ? 1 : 0);
                cyc();
            end
            exp_gap = int'(lm[5:0]);
            lm = lstep(lm);
            if (f < 7) begin
                idle = 0;
                while (!ax1.tvalid && idle < 100) begin
                    cyc();
                    idle++;
                end
                chk("rand_gap", idle, exp_gap);
            end
        end
        chk("rg_busy", int'(busy1), 0);
        chk("rg_fcnt", int'(fc1), 8);
        rand_gap = 1'b0;
        gap_len  = 6'd0;

        // infinite run stopped mid frame 3; start while busy is ignored
        n_frames = 16'd0;
        start_run();
        beats = 0; lastflag = 0;
        for (int c = 0; c < 200; c++) begin
            stop  = (beats == 27);
            start = (beats == 15);
            if (!ax1.tvalid) break;
            beats++;
            lastflag = int'(ax1.tlast);
            cyc();
        end
        stop = 1'b0;
        start = 1'b0;
        chk("stop_beats", beats, 33);
        chk("stop_last", lastflag, 1);
        chk("stop_fcnt", int'(fc1), 3);
        chk("stop_busy", int'(busy1), 0);

        // asynchronous reset in the middle of the second frame
        flip_en  = 1'b1;
        flip_idx = 5'd3;
        start_run();
        for (int c = 0; c < 13; c++) cyc();
        chk("pre_rst_tvalid", int'(ax1.tvalid), 1);
        chk("pre_rst_tuser", int'(ax1.tuser), 1);
        chk("pre_rst_fcnt", int'(fc1), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", int'(ax1.tvalid), 0);
        chk("arst_tuser", int'(ax1.tuser), 0);
        chk("arst_tlast", int'(ax1.tlast), 0);
        chk("arst_tdata8", int'(ax8.tdata), 0);
        chk("arst_busy", int'(busy1), 0);
        chk("arst_fcnt", int'(fc1), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_tvalid", int'(ax1.tvalid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
